// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_e;

  // Ticks per bit, and the tick count from the start edge to mid start bit.
  localparam int OVERSAMPLE   = 16;
  localparam int START_SAMPLE = OVERSAMPLE / 2;

  // Register offsets inside the two-entry window (address bit 0).
  localparam logic RX_DATA_OFS   = 1'b0;
  localparam logic RX_STATUS_OFS = 1'b1;

  // RX_STATUS bit positions.
  localparam int STAT_VALID     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;

  // Oversample tick divider, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud * 8) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers. The caller only asserts
// push_i when there is room (or a pop happens the same cycle) and pop_i
// only when non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: synchroniser, 16x oversample FSM,
// receive FIFO, sticky overrun/frame-error flags and a two-register window.
// Handshake: read_enable/write_enable are single-cycle strobes qualified by
// rx_sel; a read of RX_DATA pops one entry at the clock edge ending the
// strobe cycle, and a write to RX_STATUS clears flags at that same edge.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int                    CLK_FREQ_HZ = 100_000_000,
  parameter int                    BAUD        = 115200,
  parameter int                    FIFO_DEPTH  = 8,
  parameter int                    D_ADDR_W    = 12,
  parameter int                    DATA_W      = 8,
  parameter logic [D_ADDR_W-1:0]   BASE_ADDR   = 12'hFF2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RsRx,
  input  logic [D_ADDR_W-1:0] data_addr,
  input  logic                read_enable,
  input  logic                write_enable,
  input  logic [DATA_W-1:0]   write_data,
  output logic [DATA_W-1:0]   read_data,
  output logic                rx_sel,
  output logic                rx_valid
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  // Synchroniser
  logic rx_meta_q, rx_sync_q;

  // Tick generation
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic          restart_tick;

  // Receive FSM
  uart_rx_state_e state_q, state_d;
  logic [3:0]     os_cnt_q, os_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           push_q, push_d;
  logic [7:0]     push_byte_q;
  logic           frame_set;

  // FIFO and flags
  logic [7:0] fifo_head;
  logic       fifo_empty, fifo_full;
  logic       pop_en, push_en;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       is_status, w1c_en;
  logic [7:0] status;
  logic       unused_wdata;

  assign tick = (tick_cnt_q == TW'(DIV - 1));

  // Two-flop synchroniser; idles high so reset cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RsRx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Free-running tick divider, realigned to the start edge.
  always_ff @(posedge clk) begin
    if (reset || restart_tick || tick) tick_cnt_q <= '0;
    else                               tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // Next-state logic: sample mid-bit, shift LSB first, judge the stop bit.
  always_comb begin
    state_d      = state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    push_d       = 1'b0;
    frame_set    = 1'b0;
    restart_tick = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d      = START;
          os_cnt_d     = '0;
          restart_tick = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt_q == 4'(START_SAMPLE - 1)) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            // A high line at mid start bit was only a glitch.
            state_d   = rx_sync_q ? IDLE : DATA;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt_q == 4'(OVERSAMPLE - 1)) begin
            os_cnt_d  = '0;
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (os_cnt_q == 4'(OVERSAMPLE - 1)) begin
            os_cnt_d = '0;
            if (rx_sync_q) begin
              push_d  = 1'b1;
              state_d = IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = WAIT_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        // A line stuck low must not be read as a stream of start bits.
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers; reset abandons any partial byte and pending push.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_byte_q <= shift_q;
    end
  end

  // Register decode: the window is two addresses, split by bit 0.
  assign rx_sel    = (data_addr[D_ADDR_W-1:1] == BASE_ADDR[D_ADDR_W-1:1]);
  assign is_status = (data_addr[0] == RX_STATUS_OFS);
  assign pop_en    = read_enable && rx_sel && (data_addr[0] == RX_DATA_OFS) && !fifo_empty;
  assign w1c_en    = write_enable && rx_sel && is_status;
  // A full FIFO still accepts a push when a pop frees the slot this cycle.
  assign push_en   = push_q && (!fifo_full || pop_en);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_en),
    .push_data_i (push_byte_q),
    .pop_i       (pop_en),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Sticky flags: write-1-to-clear, with a same-cycle set taking priority.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (w1c_en && write_data[STAT_OVERRUN])   overrun_d   = 1'b0;
    if (w1c_en && write_data[STAT_FRAME_ERR]) frame_err_d = 1'b0;
    if (push_q && fifo_full && !pop_en)       overrun_d   = 1'b1;
    if (frame_set)                            frame_err_d = 1'b1;
  end

  // Flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_valid = !fifo_empty;

  always_comb begin
    status                 = '0;
    status[STAT_VALID]     = !fifo_empty;
    status[STAT_FULL]      = fifo_full;
    status[STAT_OVERRUN]   = overrun_q;
    status[STAT_FRAME_ERR] = frame_err_q;
  end

  // Read mux; an empty FIFO reads as zero rather than stale storage.
  always_comb begin
    read_data = '0;
    if (rx_sel) begin
      if (is_status)        read_data = DATA_W'(status);
      else if (!fifo_empty) read_data = DATA_W'(fifo_head);
    end
  end

  // Only the two W1C bits of write_data have meaning.
  assign unused_wdata = ^{write_data[DATA_W-1:4], write_data[1:0]};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: reset, single byte, overrun, glitch,
// framing error and reset mid-byte.
module tb_uart_rx_mmio;

  // Clock chosen so the divider comes out at 4 ticks (64 cycles per bit).
  localparam int          CLK_HZ = 7_372_800;
  localparam int          BAUD   = 115200;
  localparam int          BIT    = 64;
  localparam logic [11:0] BASE   = 12'hFF2;

  logic        clk;
  logic        reset;
  logic        RsRx;
  logic [11:0] data_addr;
  logic        read_enable;
  logic        write_enable;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        rx_sel;
  logic        rx_valid;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  uart_rx_mmio #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD),
    .FIFO_DEPTH  (8),
    .D_ADDR_W    (12),
    .DATA_W      (8),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RsRx         (RsRx),
    .data_addr    (data_addr),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .rx_sel       (rx_sel),
    .rx_valid     (rx_valid)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: all start and end on a falling edge.
  task automatic send_bits(input logic [7:0] b);
    RsRx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b);
    RsRx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic [7:0] exp);
    data_addr   = BASE + 12'd1;
    read_enable = 1'b1;
    #1;
    check_eq(tag, {24'd0, read_data}, {24'd0, exp});
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  // Scoreboard: each RX_DATA read must return the queue head.
  task automatic pop_and_check(input string tag);
    logic [7:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    data_addr   = BASE;
    read_enable = 1'b1;
    #1;
    check_eq(tag, {24'd0, read_data}, {24'd0, exp});
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  task automatic write_reg(input logic [11:0] addr, input logic [7:0] val);
    data_addr    = addr;
    write_data   = val;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    write_data   = 8'h00;
  endtask

  initial begin
    reset        = 1'b1;
    RsRx         = 1'b1;
    data_addr    = BASE;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    write_data   = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset values and decode boundaries
    check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_sel", {31'd0, rx_sel}, 32'd1);
    pop_and_check("rst_data");
    check_status("rst_status", 8'h00);
    data_addr = BASE - 12'd1;
    #1;
    check_eq("sel_below", {31'd0, rx_sel}, 32'd0);
    data_addr = BASE + 12'd2;
    #1;
    check_eq("sel_above", {31'd0, rx_sel}, 32'd0);
    @(negedge clk);

    // Single byte with valid timing around the stop-bit midpoint
    send_bits(8'hA5);
    RsRx = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("single_valid_early", {31'd0, rx_valid}, 32'd0);
    repeat (BIT - 10) @(negedge clk);
    check_eq("single_valid_late", {31'd0, rx_valid}, 32'd1);
    check_status("single_status", 8'h01);
    data_addr   = 12'h100;
    read_enable = 1'b1;
    #1;
    check_eq("outside_rdata", {24'd0, read_data}, 32'd0);
    @(negedge clk);
    read_enable = 1'b0;
    check_status("outside_no_pop", 8'h01);
    exp_q.push_back(8'hA5);
    pop_and_check("single_data");
    check_status("single_after_pop", 8'h00);

    // Overrun: nine bytes into eight slots
    for (int i = 0; i < 9; i++) send_byte(8'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    check_status("ovr_status", 8'h07);
    for (int i = 0; i < 8; i++) pop_and_check($sformatf("ovr_data%0d", i));
    check_status("ovr_drained", 8'h04);
    write_reg(BASE, 8'h04);
    check_status("ovr_data_write_ignored", 8'h04);
    write_reg(BASE + 12'd1, 8'hF3);
    check_status("ovr_other_bits_ignored", 8'h04);
    write_reg(BASE + 12'd1, 8'h04);
    check_status("ovr_cleared", 8'h00);

    // Glitch shorter than half a bit
    RsRx = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    RsRx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check_status("glitch_status", 8'h00);
    check_eq("glitch_valid", {31'd0, rx_valid}, 32'd0);

    // Framing error, line held low, then recovery
    send_bits(8'h55);
    RsRx = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    check_status("frame_status", 8'h08);
    RsRx = 1'b1;
    repeat (BIT) @(negedge clk);
    send_byte(8'h3C);
    check_status("frame_recv_status", 8'h09);
    exp_q.push_back(8'h3C);
    pop_and_check("frame_recv_data");
    write_reg(BASE + 12'd1, 8'h08);
    check_status("frame_cleared", 8'h00);

    // Reset in data bit 3 with an unread byte already buffered
    send_byte(8'h77);
    check_status("pre_reset_status", 8'h01);
    RsRx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      RsRx = (i == 1);
      repeat (BIT) @(negedge clk);
    end
    RsRx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    RsRx  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check_status("midrst_flushed", 8'h00);
    send_byte(8'h34);
    check_status("midrst_status", 8'h01);
    exp_q.push_back(8'h34);
    pop_and_check("midrst_data");
    check_status("midrst_empty", 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_mmio.md
# uart_rx_mmio

Memory-mapped UART receiver for the Basys3 wrapper. It deserialises bytes arriving on `RsRx` (8N1, LSB first) and buffers them in a small FIFO. It exposes a data register and a status register to the core's data-memory interface, and is the receive-side counterpart of the existing UART transmit path on `RsTx`. It sits beside `io_controller` and decodes its own address window.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000: `clk` frequency.
- `BAUD`, 115200: line rate.
- `FIFO_DEPTH`, 8: receive buffer entries; must be a power of two, ≥2.
- `D_ADDR_W`, 12: data address width.
- `DATA_W`, 8: data bus width.
- `BASE_ADDR`, 12'hFF2: register window base; must be 2-aligned.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `RsRx`  in  1  asynchronous serial input; idles high.
- `data_addr`  in  D_ADDR_W  core data address.
- `read_enable`  in  1  single-cycle core read strobe.
- `write_enable`  in  1  single-cycle core write strobe.
- `write_data`  in  DATA_W  core write data.
- `read_data`  out  DATA_W  register read data; combinational.
- `rx_sel`  out  1  high when `data_addr` is in the window; combinational.
- `rx_valid`  out  1  FIFO non-empty; registered level.

## Operation
- **Register map:**
  - BASE+0 `RX_DATA` (RO): FIFO head. A read with `read_enable` pops one entry.
  - BASE+1 `RX_STATUS`: bit0 valid, bit1 full, bit2 overrun, bit3 frame_err, bits7:4 read as 0. Writing 1 to bit2 or bit3 clears that bit (W1C). Writes to other bits, and any write to BASE+0, are ignored.
- **Address decode:** `rx_sel` = (`data_addr[D_ADDR_W-1:1]` == `BASE_ADDR[D_ADDR_W-1:1]`).
- **read_data:** 8'h00 when `rx_sel` is low, or when reading BASE+0 with the FIFO empty.
- **Input sync:** `RsRx` passes through a 2-flop synchroniser (flops reset to 1).
- **Oversample tick:** DIV = (CLK_FREQ_HZ + BAUD*8) / (BAUD*16), i.e. 54 at the defaults. The tick counter free-runs, restarting when the FSM enters START.
- **FSM states:**
  - IDLE: on synced low, go to START.
  - START: after 8 ticks (mid start bit), sample. If high, the start was a glitch; go to IDLE. If low, go to DATA.
  - DATA: sample every 16 ticks, 8 bits, LSB first, then go to STOP.
  - STOP: sample after 16 ticks.
    - If high: push the byte and go to IDLE.
    - If low: set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synced line is high, then go to IDLE.
- **Push when full:** the byte is dropped, overrun is set, and FIFO contents are unchanged.
- **Push and pop in the same cycle:**
  - FIFO full: both take effect; occupancy unchanged; no overrun.
  - FIFO empty: the pop is ignored; the push lands.
- **Pop when empty:** ignored; no state change.

## Timing
- **Reset** (takes effect at the next `clk` edge while high):
  - FIFO empty; FSM in IDLE.
  - overrun, frame_err and `rx_valid` all 0.
  - `read_data` 0, since it is driven only by registered state.
- **Reset mid-frame:** the partial byte is abandoned; the FIFO is flushed.
- **Push latency:** the byte is written into the FIFO on the clk edge after the stop-bit sample. `rx_valid` and status bit0 are high on the following cycle.
- **Pop:** takes effect at the clk edge ending the `read_enable` cycle. The next head (or 0) is visible in the next cycle.
- **W1C:** clears take effect at the clk edge ending the `write_enable` cycle. If a flag is set and cleared in the same cycle, set wins.
- **Synchroniser delay:** 2 cycles. Total sample-point skew is under 1 tick.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_e` enum (IDLE, START, DATA, STOP, WAIT_IDLE).
  - `OVERSAMPLE` = 16.
  - Register offsets `RX_DATA_OFS` = 0, `RX_STATUS_OFS` = 1.
  - Status bit-index constants.
- Sub-module `sync_fifo`, parameterised by width and depth:
  - Inputs: push/pop.
  - Outputs: head data, empty, full.
  - Pointers carry 1 extra wrap bit.
- Top level holds the synchroniser, tick counter, FSM, shift register, flags and register decode.

## Test plan
Defaults apply throughout; 1 bit ≈ 864 cycles.

- **Reset values:** hold `reset` 2 cycles with `RsRx`=1. Expected: `RX_STATUS`=8'h00, `rx_valid`=0, BASE+0 reads 8'h00.
- **Single byte:** send 0xA5. Expected: `rx_valid` rises after the stop-bit midpoint; status=8'h01. A read of BASE+0 returns 8'hA5; the next cycle's status is 8'h00.
- **Overrun:** send 0x00..0x08 back-to-back with no reads.
  - Status=8'h07.
  - Eight reads return 0x00..0x07; status is then 8'h04.
  - Writing 8'h04 to BASE+1 brings status to 8'h00.
- **Glitch:** drive `RsRx` low for 200 cycles, then high. Expected: no push; status stays 8'h00.
- **Framing error:** send 0x55 with the stop bit low, then hold low for 2 bit times. Expected: status=8'h08, FIFO empty. Raise the line and send 0x3C: it is received, and status=8'h09.
- **Reset mid-byte:** assert `reset` for 1 cycle during data bit 3 of 0x12, then send 0x34. Expected: only 0x34 in the FIFO.
